hwregs_arbiter: RTL and testbench
=================================

HWREGS_ARBITER -- requirements
Module: hwregs_arbiter

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning.
- clock  in  1  system clock; reset reset, synchronous, active-high; clock clock.
- reset  in  1  synchronous active-high reset.
REQ-002 Master ports SHALL exist for N in {0 (CPU), 1 (debug/DMA)}:
- mN_valid  in  1  request present.
- mN_ready  out  1  request accepted when valid&ready.
- mN_write  in  1  1=write, 0=read.
- mN_addr  in  16  register offset.
- mN_wmask  in  4  byte enables.
- mN_wdata  in  32  write data; on reads, bits [8:0] carry the tag.
- mN_rvalid  out  1  read response.
- mN_rtag  out  9  returned tag.
- mN_rdata  out  32  read data.
REQ-003 Slave ports SHALL be:
- hwregs_request, hwregs_write  out  1  toward hwregs.
- hwregs_addr  out  16.
- hwregs_wmask  out  4.
- hwregs_wdata  out  32.
- hwregs_rvalid  in  1.
- hwregs_rtag  in  9.
- hwregs_rdata  in  32.
- arb_error  out  1  sticky; set by an unexpected response.

Function
REQ-004 Each master SHALL have a one-entry holding buffer (full flag plus write/addr/wmask/wdata); mN_ready SHALL equal !fullN, registered.
REQ-005 When mN_valid&mN_ready, the buffer SHALL capture the request and set fullN at the next edge.
REQ-006 Each cycle, the arbiter SHALL choose among full buffers:
- one full: grant it.
- both full: grant the master other than last_grant.
- none full: no grant.
REQ-007 On a grant, the buffer contents SHALL be registered onto hwregs_* with hwregs_request=1 the next cycle, fullN SHALL clear at that same edge, and last_grant SHALL update to N.
REQ-008 With no grant, hwregs_request SHALL be 0 and hwregs_addr/wmask/wdata/write SHALL hold their previous values.
REQ-009 At most one hwregs_request SHALL be issued per cycle.
REQ-010 Minimum latency SHALL be: accept at T, fullN=1 at T+1, hwregs_request at T+2, hwregs_rvalid at T+3, mN_rvalid at T+3 (combinational routing).
REQ-011 For every granted read, an owner bit (N) and a valid bit SHALL be pushed into a 4-entry owner FIFO at the issue edge; writes SHALL push nothing.
REQ-012 On hwregs_rvalid with the owner FIFO non-empty, the arbiter SHALL pop the head and drive m<head>_rvalid=1 with rtag/rdata passed through, keeping the other master's rvalid at 0.
REQ-013 On hwregs_rvalid with the owner FIFO empty, the response SHALL be dropped and arb_error SHALL be set (sticky until reset).
REQ-014 A push and a pop in the same cycle SHALL leave the occupancy unchanged; the FIFO pointers SHALL be 2-bit and wrap modulo 4.
REQ-015 While the owner FIFO holds 4 entries, no read grant SHALL issue; a pending write MAY be granted instead, and the round-robin rule still applies.
REQ-016 A grant SHALL never be given to a buffer that is filling in the same cycle; arbitration SHALL use only fullN as registered at the start of the cycle.
REQ-017 mN_rtag and mN_rdata SHALL be don't-care when mN_rvalid=0.

Reset
REQ-018 Reset SHALL set:
- full0, full1 = 0, so m0_ready and m1_ready = 1 in the cycle after reset.
- hwregs_request = 0; hwregs_write = 0; hwregs_addr/wmask/wdata = 0.
- last_grant = 1, so m0 wins the first tie.
- owner FIFO empty, pointers 0.
- arb_error = 0.
- m0_rvalid and m1_rvalid = 0.
REQ-019 Reset mid-operation SHALL discard buffered and outstanding requests; responses arriving after reset SHALL hit the empty FIFO, be dropped, and set arb_error.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single read: m0 read addr 0x0030 tag 0x05 at T, hwregs model returns 0x1234 -> hwregs_request at T+2, m0_rvalid at T+3 with rtag=0x05 and rdata=0x1234, m1_rvalid=0 throughout.
- Tie: both masters assert a read in the same cycle after reset -> m0 issued first, m1 the next cycle, each response routed to its own port with its own tag.
- Sustained contention: both masters hold valid for 20 cycles -> issues alternate 0,1,0,1...; neither master waits more than 2 issue slots.
- Mixed traffic: m1 write 0x0018 data 0xDEADBEEF interleaved with m0 reads -> write appears on hwregs with wmask intact, no response generated, m0 responses correctly ordered.
- Owner FIFO full: the hwregs model withholds rvalid for 4 issued reads -> the 5th read is not issued until the first response arrives; a pending write still issues.
- Stray response and reset: hwregs_rvalid with nothing outstanding -> arb_error=1, no mN_rvalid; then reset asserted with 2 reads in flight -> all state cleared, late responses dropped.

Source files
------------

// File: rtl/hwregs_arbiter.sv
// hwregs_arbiter
// Two-master arbiter in front of the hwregs register block.
//   clock, reset      : system clock, synchronous active-high reset
//   m0_* (CPU), m1_* (debug/DMA):
//     mN_valid/mN_ready : request handshake; a one-entry holding buffer per master
//     mN_write, mN_addr, mN_wmask, mN_wdata : request payload (wdata[8:0] = tag on reads)
//     mN_rvalid, mN_rtag, mN_rdata          : read response routed back to the owner
//   hwregs_*          : single registered request port toward hwregs plus response input
//   arb_error         : sticky flag, set when a response arrives with nothing outstanding
module hwregs_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_write,
  input  logic [15:0] m0_addr,
  input  logic [3:0]  m0_wmask,
  input  logic [31:0] m0_wdata,
  output logic        m0_rvalid,
  output logic [8:0]  m0_rtag,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_write,
  input  logic [15:0] m1_addr,
  input  logic [3:0]  m1_wmask,
  input  logic [31:0] m1_wdata,
  output logic        m1_rvalid,
  output logic [8:0]  m1_rtag,
  output logic [31:0] m1_rdata,
  output logic        hwregs_request,
  output logic        hwregs_write,
  output logic [15:0] hwregs_addr,
  output logic [3:0]  hwregs_wmask,
  output logic [31:0] hwregs_wdata,
  input  logic        hwregs_rvalid,
  input  logic [8:0]  hwregs_rtag,
  input  logic [31:0] hwregs_rdata,
  output logic        arb_error
);

  logic        full0, full1;
  logic        buf0_write_p0, buf1_write_p0;
  logic [15:0] buf0_addr_p0, buf1_addr_p0;
  logic [3:0]  buf0_wmask_p0, buf1_wmask_p0;
  logic [31:0] buf0_wdata_p0, buf1_wdata_p0;
  logic        last_grant;

  // Owner FIFO: one entry per outstanding read, bit = owning master.
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic [3:0]  own_q, own_vld;

  logic accept0, accept1, fifo_full, fifo_empty;
  logic elig0, elig1, gnt0, gnt1, gnt_write, push, pop;

  assign m0_ready   = ~full0;
  assign m1_ready   = ~full1;
  assign accept0    = m0_valid & ~full0;
  assign accept1    = m1_valid & ~full1;
  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = ~own_vld[rd_ptr];

  // A read cannot issue while all four owner slots are taken; writes still can.
  assign elig0 = full0 & (buf0_write_p0 | ~fifo_full);
  assign elig1 = full1 & (buf1_write_p0 | ~fifo_full);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (elig0 && elig1) begin
      if (last_grant) gnt0 = 1'b1;
      else            gnt1 = 1'b1;
    end else if (elig0) begin
      gnt0 = 1'b1;
    end else if (elig1) begin
      gnt1 = 1'b1;
    end
  end

  assign gnt_write = gnt0 ? buf0_write_p0 : buf1_write_p0;
  assign push      = (gnt0 | gnt1) & ~gnt_write;
  assign pop       = hwregs_rvalid & ~fifo_empty;

  // Stage p0: holding buffers capture the payload on handshake
  always_ff @(posedge clock) begin
    if (accept0) begin
      buf0_write_p0 <= m0_write;
      buf0_addr_p0  <= m0_addr;
      buf0_wmask_p0 <= m0_wmask;
      buf0_wdata_p0 <= m0_wdata;
    end
    if (accept1) begin
      buf1_write_p0 <= m1_write;
      buf1_addr_p0  <= m1_addr;
      buf1_wmask_p0 <= m1_wmask;
      buf1_wdata_p0 <= m1_wdata;
    end
  end

  // Stage p1: granted buffer is issued on the hwregs port, owner FIFO tracks reads
  always_ff @(posedge clock) begin
    if (reset) begin
      full0          <= 1'b0;
      full1          <= 1'b0;
      last_grant     <= 1'b1;
      hwregs_request <= 1'b0;
      hwregs_write   <= 1'b0;
      hwregs_addr    <= 16'h0000;
      hwregs_wmask   <= 4'h0;
      hwregs_wdata   <= 32'h0000_0000;
      wr_ptr         <= 2'd0;
      rd_ptr         <= 2'd0;
      count          <= 3'd0;
      own_vld        <= 4'h0;
      arb_error      <= 1'b0;
    end else begin
      // Grant only ever targets a buffer already full, so fill and drain never collide.
      if (accept0)   full0 <= 1'b1;
      else if (gnt0) full0 <= 1'b0;
      if (accept1)   full1 <= 1'b1;
      else if (gnt1) full1 <= 1'b0;

      hwregs_request <= gnt0 | gnt1;
      if (gnt0) begin
        hwregs_write <= buf0_write_p0;
        hwregs_addr  <= buf0_addr_p0;
        hwregs_wmask <= buf0_wmask_p0;
        hwregs_wdata <= buf0_wdata_p0;
        last_grant   <= 1'b0;
      end else if (gnt1) begin
        hwregs_write <= buf1_write_p0;
        hwregs_addr  <= buf1_addr_p0;
        hwregs_wmask <= buf1_wmask_p0;
        hwregs_wdata <= buf1_wdata_p0;
        last_grant   <= 1'b1;
      end

      if (push) begin
        own_q[wr_ptr]   <= gnt1;
        own_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (pop) begin
        own_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (hwregs_rvalid && fifo_empty) arb_error <= 1'b1;
    end
  end

  // Responses route combinationally to the owner at the FIFO head.
  assign m0_rvalid = ~reset & pop & ~own_q[rd_ptr];
  assign m1_rvalid = ~reset & pop &  own_q[rd_ptr];
  assign m0_rtag   = hwregs_rtag;
  assign m1_rtag   = hwregs_rtag;
  assign m0_rdata  = hwregs_rdata;
  assign m1_rdata  = hwregs_rdata;

endmodule

// File: tb/tb_hwregs_arbiter.sv
// tb_hwregs_arbiter
// Directed bench for hwregs_arbiter with a small hwregs responder model that
// answers each read one cycle after the request (optionally withheld) with
// rtag = request tag and rdata = {16'h0, addr ^ 16'h1204}.
module tb_hwregs_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m0_write = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [3:0]  m0_wmask = '0;
  logic [31:0] m0_wdata = '0;
  logic        m0_ready, m0_rvalid;
  logic [8:0]  m0_rtag;
  logic [31:0] m0_rdata;
  logic        m1_valid = 1'b0, m1_write = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [3:0]  m1_wmask = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_ready, m1_rvalid;
  logic [8:0]  m1_rtag;
  logic [31:0] m1_rdata;
  logic        hwregs_request, hwregs_write;
  logic [15:0] hwregs_addr;
  logic [3:0]  hwregs_wmask;
  logic [31:0] hwregs_wdata;
  logic        hwregs_rvalid = 1'b0;
  logic [8:0]  hwregs_rtag = '0;
  logic [31:0] hwregs_rdata = '0;
  logic        arb_error;

  hwregs_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wmask(m0_wmask), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rtag(m0_rtag),
    .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wmask(m1_wmask), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rtag(m1_rtag),
    .m1_rdata(m1_rdata),
    .hwregs_request(hwregs_request), .hwregs_write(hwregs_write), .hwregs_addr(hwregs_addr),
    .hwregs_wmask(hwregs_wmask), .hwregs_wdata(hwregs_wdata), .hwregs_rvalid(hwregs_rvalid),
    .hwregs_rtag(hwregs_rtag), .hwregs_rdata(hwregs_rdata), .arb_error(arb_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // hwregs responder model
  logic        hold = 1'b0, stray = 1'b0;
  logic [24:0] mq[$];
  logic [24:0] me;
  always @(posedge clock) begin
    if (hwregs_request && !hwregs_write) mq.push_back({hwregs_wdata[8:0], hwregs_addr});
    if (stray) begin
      hwregs_rvalid <= 1'b1;
      hwregs_rtag   <= 9'h1FF;
      hwregs_rdata  <= 32'h0BAD_0BAD;
    end else if (!hold && mq.size() > 0) begin
      me = mq.pop_front();
      hwregs_rvalid <= 1'b1;
      hwregs_rtag   <= me[24:16];
      hwregs_rdata  <= {16'h0000, me[15:0] ^ 16'h1204};
    end else begin
      hwregs_rvalid <= 1'b0;
    end
  end

  // Event logs sampled on the falling edge
  typedef struct {logic w; logic [15:0] a; logic [3:0] k; logic [31:0] d; int c;} iss_t;
  typedef struct {logic [8:0] t; logic [31:0] d; int c;} rsp_t;
  iss_t iss_q[$];
  rsp_t r0_q[$], r1_q[$];
  always @(negedge clock) begin
    if (!reset) begin
      if (hwregs_request) iss_q.push_back('{hwregs_write, hwregs_addr, hwregs_wmask, hwregs_wdata, cyc});
      if (m0_rvalid) r0_q.push_back('{m0_rtag, m0_rdata, cyc});
      if (m1_rvalid) r1_q.push_back('{m1_rtag, m1_rdata, cyc});
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    iss_q.delete();
    r0_q.delete();
    r1_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input int m, input logic w, input logic [15:0] a,
                      input logic [3:0] k, input logic [31:0] d);
    int n = 0;
    logic rdy;
    if (m == 0) begin
      m0_valid = 1'b1; m0_write = w; m0_addr = a; m0_wmask = k; m0_wdata = d;
    end else begin
      m1_valid = 1'b1; m1_write = w; m1_addr = a; m1_wmask = k; m1_wdata = d;
    end
    forever begin
      @(negedge clock);
      rdy = (m == 0) ? m0_ready : m1_ready;
      if (rdy) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clock);
    #1;
    if (m == 0) m0_valid = 1'b0;
    else        m1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int idx5;

    // Reset state
    do_reset();
    @(negedge clock);
    chk("rst_m0_ready", m0_ready, 1);
    chk("rst_m1_ready", m1_ready, 1);
    chk("rst_request", hwregs_request, 0);
    chk("rst_write", hwregs_write, 0);
    chk("rst_addr", hwregs_addr, 0);
    chk("rst_wmask", hwregs_wmask, 0);
    chk("rst_wdata", hwregs_wdata, 0);
    chk("rst_arb_error", arb_error, 0);
    chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);

    // Single read with exact latency
    tick();
    send(0, 1'b0, 16'h0030, 4'hF, 32'h0000_0005);
    @(negedge clock);
    chk("single_t1_ready", m0_ready, 0);
    chk("single_t1_req", hwregs_request, 0);
    @(negedge clock);
    chk("single_t2_req", hwregs_request, 1);
    chk("single_t2_addr", hwregs_addr, 32'h0030);
    chk("single_t2_write", hwregs_write, 0);
    chk("single_t2_tag", hwregs_wdata[8:0], 32'h005);
    chk("single_t2_rvalid", m0_rvalid, 0);
    @(negedge clock);
    chk("single_t3_rvalid", m0_rvalid, 1);
    chk("single_t3_rtag", m0_rtag, 32'h005);
    chk("single_t3_rdata", m0_rdata, 32'h0000_1234);
    chk("single_t3_m1_rvalid", m1_rvalid, 0);
    chk("single_t3_req", hwregs_request, 0);
    tick();
    repeat (3) tick();
    chk("single_m1_rsp_count", r1_q.size(), 0);
    chk("single_m0_rsp_count", r0_q.size(), 1);

    // Tie after reset: m0 first, m1 next cycle
    do_reset();
    fork
      send(0, 1'b0, 16'h0040, 4'hF, 32'h0000_0011);
      send(1, 1'b0, 16'h0050, 4'hF, 32'h0000_0022);
    join
    repeat (6) tick();
    chk("tie_issue_count", iss_q.size(), 2);
    if (iss_q.size() == 2) begin
      chk("tie_first_addr", iss_q[0].a, 32'h0040);
      chk("tie_second_addr", iss_q[1].a, 32'h0050);
      chk("tie_consecutive", 32'(iss_q[1].c - iss_q[0].c), 1);
    end
    chk("tie_r0_count", r0_q.size(), 1);
    chk("tie_r1_count", r1_q.size(), 1);
    if (r0_q.size() == 1) begin
      chk("tie_r0_tag", r0_q[0].t, 32'h011);
      chk("tie_r0_data", r0_q[0].d, 32'h0000_1244);
    end
    if (r1_q.size() == 1) begin
      chk("tie_r1_tag", r1_q[0].t, 32'h022);
      chk("tie_r1_data", r1_q[0].d, 32'h0000_1254);
    end

    // Sustained contention for 20 cycles
    do_reset();
    m0_write = 1'b0; m0_addr = 16'h0100; m0_wmask = 4'hF; m0_wdata = 32'h1;
    m1_write = 1'b0; m1_addr = 16'h0200; m1_wmask = 4'hF; m1_wdata = 32'h2;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    repeat (20) tick();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    repeat (8) tick();
    chk("sust_issue_count", iss_q.size(), 20);
    bad = 0;
    for (int i = 0; i < iss_q.size(); i++) begin
      if (iss_q[i].a != ((i % 2 == 0) ? 16'h0100 : 16'h0200)) bad++;
      if (i > 0 && iss_q[i].c != iss_q[i-1].c + 1) bad++;
    end
    chk("sust_alternation", 32'(bad), 0);
    chk("sust_r0_count", r0_q.size(), 10);
    chk("sust_r1_count", r1_q.size(), 10);
    bad = 0;
    foreach (r0_q[i]) if (r0_q[i].t != 9'h001 || r0_q[i].d != 32'h0000_1304) bad++;
    foreach (r1_q[i]) if (r1_q[i].t != 9'h002 || r1_q[i].d != 32'h0000_1004) bad++;
    chk("sust_rsp_routing", 32'(bad), 0);

    // Mixed traffic: m1 write among m0 reads
    do_reset();
    fork
      send(1, 1'b1, 16'h0018, 4'hA, 32'hDEAD_BEEF);
      begin
        send(0, 1'b0, 16'h0060, 4'hF, 32'h0000_0031);
        send(0, 1'b0, 16'h0070, 4'hF, 32'h0000_0032);
        send(0, 1'b0, 16'h0080, 4'hF, 32'h0000_0033);
      end
    join
    repeat (8) tick();
    chk("mix_issue_count", iss_q.size(), 4);
    if (iss_q.size() == 4) begin
      chk("mix_i0_addr", iss_q[0].a, 32'h0060);
      chk("mix_i1_write", iss_q[1].w, 1);
      chk("mix_i1_addr", iss_q[1].a, 32'h0018);
      chk("mix_i1_wmask", iss_q[1].k, 32'hA);
      chk("mix_i1_wdata", iss_q[1].d, 32'hDEAD_BEEF);
      chk("mix_i2_addr", iss_q[2].a, 32'h0070);
      chk("mix_i3_addr", iss_q[3].a, 32'h0080);
    end
    chk("mix_r1_count", r1_q.size(), 0);
    chk("mix_r0_count", r0_q.size(), 3);
    if (r0_q.size() == 3) begin
      chk("mix_r0_order", {r0_q[0].t, r0_q[1].t, r0_q[2].t}, {5'd0, 9'h031, 9'h032, 9'h033});
      chk("mix_r0_data2", r0_q[2].d, 32'h0000_1284);
    end

    // Owner FIFO full: 5th read waits for first response, write still issues
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 5; i++)
      send(0, 1'b0, 16'h0090 + 16'(i * 4), 4'hF, 32'h41 + 32'(i));
    send(1, 1'b1, 16'h0020, 4'h3, 32'h0BAD_F00D);
    repeat (4) tick();
    @(negedge clock);
    chk("ffull_issue_count", iss_q.size(), 5);
    if (iss_q.size() == 5) begin
      chk("ffull_write_issued", iss_q[4].w, 1);
      chk("ffull_write_addr", iss_q[4].a, 32'h0020);
      chk("ffull_read4_addr", iss_q[3].a, 32'h009C);
    end
    chk("ffull_m0_held", m0_ready, 0);
    chk("ffull_no_rsp", r0_q.size(), 0);
    tick();
    hold = 1'b0;
    repeat (12) tick();
    chk("ffull_issue_count2", iss_q.size(), 6);
    chk("ffull_r0_count", r0_q.size(), 5);
    if (iss_q.size() == 6 && r0_q.size() == 5) begin
      chk("ffull_read5_addr", iss_q[5].a, 32'h00A0);
      chk("ffull_read5_after_rsp", 32'(iss_q[5].c - r0_q[0].c), 2);
      bad = 0;
      foreach (r0_q[i]) if (r0_q[i].t != 9'h041 + 9'(i)) bad++;
      chk("ffull_rsp_order", 32'(bad), 0);
    end

    // Stray response sets sticky arb_error
    do_reset();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    @(negedge clock);
    chk("stray_m0_rvalid", m0_rvalid, 0);
    chk("stray_m1_rvalid", m1_rvalid, 0);
    @(negedge clock);
    chk("stray_arb_error", arb_error, 1);
    repeat (3) @(negedge clock);
    chk("stray_sticky", arb_error, 1);

    // Reset with two reads in flight; late responses dropped
    tick();
    do_reset();
    @(negedge clock);
    chk("rst2_arb_error_clear", arb_error, 0);
    tick();
    hold = 1'b1;
    fork
      send(0, 1'b0, 16'h00B0, 4'hF, 32'h0000_0051);
      send(1, 1'b0, 16'h00C0, 4'hF, 32'h0000_0052);
    join
    repeat (4) tick();
    chk("rst2_inflight", iss_q.size(), 2);
    do_reset();
    @(negedge clock);
    chk("rst2_m0_ready", m0_ready, 1);
    chk("rst2_m1_ready", m1_ready, 1);
    chk("rst2_request", hwregs_request, 0);
    chk("rst2_addr", hwregs_addr, 0);
    tick();
    hold = 1'b0;
    repeat (6) tick();
    chk("rst2_r0_dropped", r0_q.size(), 0);
    chk("rst2_r1_dropped", r1_q.size(), 0);
    chk("rst2_arb_error", arb_error, 1);
    chk("rst2_no_issue", iss_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
